// File: rtl/ifetch_arbiter_pkg.sv
// Shared constants for the instruction-fetch arbiter and its MemController peer.
// Holds default widths, the block-width helper and the IDLE/BUSY encodings.
// No logic; import with ifetch_arbiter_pkg::*.
package ifetch_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int BLOCK_WIDTH_DEF = 1;
  localparam int AGE_WIDTH_DEF   = 4;

  // Same encodings as the MemController state constants.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // One block holds 2^bw 32-bit instructions.
  function automatic int blk_bits(input int bw);
    return 32 << bw;
  endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter used to stop the prefetcher from starving.
// Latency: count updates on the clock after inc/clr; sat is registered state.
// Backpressure: en low holds the count; clr has priority over inc.
module arb_age_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign sat = &cnt_q;

  // Next count: clear wins, otherwise count up until all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, frozen while the system is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch_arbiter.sv
// Shares the MemController instruction-block port between demand misses and the
// next-line prefetcher; grant -> ICMC_en next cycle, response pulses in the MCIC_en cycle.
// One transaction in flight; others wait (level requests). Optional MEM_ARB_AGE_EN adds prefetch aging.
module ifetch_arbiter
  import ifetch_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF
`ifdef MEM_ARB_AGE_EN
  , parameter int AGE_WIDTH = AGE_WIDTH_DEF
`endif
) (
  input  logic                                Sys_clk,
  input  logic                                Sys_rst,
  input  logic                                Sys_rdy,
  input  logic                                Sys_flush,
  input  logic                                ICARB_en,
  input  logic [ADDR_WIDTH-1:0]               ICARB_addr,
  output logic                                ARBIC_en,
  input  logic                                PFARB_en,
  input  logic [ADDR_WIDTH-1:0]               PFARB_addr,
  output logic                                ARBPF_en,
  output logic [blk_bits(BLOCK_WIDTH)-1:0]    ARB_block,
  output logic                                ICMC_en,
  output logic [ADDR_WIDTH-1:0]               ICMC_addr,
  input  logic                                MCIC_en,
  input  logic [blk_bits(BLOCK_WIDTH)-1:0]    MCIC_block
);

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic                  own_ic_q, own_ic_d;
  logic                  own_pf_q, own_pf_d;
  logic                  drop_q, drop_d;
  logic                  ic_match, pf_match;
  logic                  pf_force;

  // A requester for the block already in flight can share its response,
  // unless a flush has already condemned that response.
  assign ic_match = ICARB_en && (ICARB_addr == cur_addr_q) && !drop_q;
  assign pf_match = PFARB_en && (PFARB_addr == cur_addr_q) && !drop_q;

  // Request drops in the completion cycle so MemController never sees it twice.
  assign ICMC_en   = (state_q == ST_BUSY) && !MCIC_en;
  assign ICMC_addr = cur_addr_q;
  assign ARB_block = MCIC_block;

`ifdef MEM_ARB_AGE_EN
  logic age_sat;
  logic pf_served;

  // Prefetch counts as served when granted, merged, or answered.
  assign pf_served = ARBPF_en || (own_pf_d && !own_pf_q);
  // Saturated age lets the prefetch jump a demand for a different block.
  assign pf_force  = age_sat && PFARB_en && !(ICARB_en && (ICARB_addr == PFARB_addr));

  arb_age_counter #(.WIDTH(AGE_WIDTH)) u_age (
    .clk (Sys_clk),
    .rst (Sys_rst),
    .en  (Sys_rdy),
    .clr (pf_served || Sys_flush),
    .inc (PFARB_en && !own_pf_q && !pf_served),
    .sat (age_sat)
  );
`else
  assign pf_force = 1'b0;
`endif

  // Grant, merge, flush and completion decisions; nothing moves while Sys_rdy is low.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    own_ic_d   = own_ic_q;
    own_pf_d   = own_pf_q;
    drop_d     = drop_q;
    ARBIC_en   = 1'b0;
    ARBPF_en   = 1'b0;
    if (Sys_rdy) begin
      if (state_q == ST_IDLE) begin
        if (!Sys_flush) begin
          if (ICARB_en && !pf_force) begin
            state_d    = ST_BUSY;
            cur_addr_d = ICARB_addr;
            own_ic_d   = 1'b1;
            own_pf_d   = PFARB_en && (PFARB_addr == ICARB_addr);
          end else if (PFARB_en) begin
            state_d    = ST_BUSY;
            cur_addr_d = PFARB_addr;
            own_ic_d   = 1'b0;
            own_pf_d   = 1'b1;
          end
        end
      end else if (MCIC_en) begin
        ARBIC_en = (own_ic_q || ic_match) && !drop_q && !Sys_flush;
        ARBPF_en = (own_pf_q || pf_match) && !drop_q && !Sys_flush;
        state_d  = ST_IDLE;
        own_ic_d = 1'b0;
        own_pf_d = 1'b0;
        drop_d   = 1'b0;
      end else if (Sys_flush) begin
        drop_d = 1'b1;
      end else begin
        if (ic_match) own_ic_d = 1'b1;
        if (pf_match) own_pf_d = 1'b1;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      own_ic_q   <= 1'b0;
      own_pf_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      own_ic_q   <= own_ic_d;
      own_pf_q   <= own_pf_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifetch_arbiter.sv
// Directed bench for ifetch_arbiter with a 10-cycle MemController model.
// Expected timing and addresses are hand-derived per scenario.
// Define MEM_ARB_AGE_EN to build with AGE_WIDTH=2 and check prefetch aging.
module tb_ifetch_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic        arbic_en;
  logic        pf_en;
  logic [31:0] pf_addr;
  logic        arbpf_en;
  logic [63:0] arb_block;
  logic        icmc_en;
  logic [31:0] icmc_addr;
  logic        mcic_en;
  logic [63:0] mcic_block;

  int n_vec;
  int n_err;
  int mc_cnt;
  int mc_txn;
  int txn0;

  ifetch_arbiter #(
    .ADDR_WIDTH (32),
    .BLOCK_WIDTH(1)
`ifdef MEM_ARB_AGE_EN
    , .AGE_WIDTH(2)
`endif
  ) dut (
    .Sys_clk   (clk),
    .Sys_rst   (rst),
    .Sys_rdy   (rdy),
    .Sys_flush (flush),
    .ICARB_en  (ic_en),
    .ICARB_addr(ic_addr),
    .ARBIC_en  (arbic_en),
    .PFARB_en  (pf_en),
    .PFARB_addr(pf_addr),
    .ARBPF_en  (arbpf_en),
    .ARB_block (arb_block),
    .ICMC_en   (icmc_en),
    .ICMC_addr (icmc_addr),
    .MCIC_en   (mcic_en),
    .MCIC_block(mcic_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] blk_of(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs change 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // MemController: answers 10 cycles after ICMC_en first goes high.
  initial begin
    mc_cnt = 0;
    mc_txn = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (mcic_en) mcic_en = 1'b0;
        if (mc_cnt == 10) begin
          mcic_en    = 1'b1;
          mcic_block = blk_of(icmc_addr);
          mc_cnt     = 0;
        end else if (icmc_en) begin
          if (mc_cnt == 0) mc_txn++;
          mc_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    ic_en = 1'b0; ic_addr = '0; pf_en = 1'b0; pf_addr = '0;
    mcic_en = 1'b0; mcic_block = 64'hDEAD_BEEF_0123_4567;

    // Reset values
    #13;
    chk("rst_icmc_en",   icmc_en,   0);
    chk("rst_icmc_addr", icmc_addr, 0);
    chk("rst_arbic",     arbic_en,  0);
    chk("rst_arbpf",     arbpf_en,  0);
    chk("rst_block",     arb_block, 64'hDEAD_BEEF_0123_4567);
    step();
    rst = 1'b0;
    mcic_block = '0;
    steps(2);

    // Lone demand 0x100
    ic_en = 1'b1; ic_addr = 32'h100;
    settle(); chk("t1_idle", icmc_en, 0);
    step(); settle();
    chk("t1_req_en", icmc_en, 1);
    chk("t1_req_addr", icmc_addr, 32'h100);
    steps(9); settle();
    chk("t1_early", arbic_en, 0);
    step(); settle();
    chk("t1_arbic", arbic_en, 1);
    chk("t1_arbpf", arbpf_en, 0);
    chk("t1_block", arb_block, blk_of(32'h100));
    chk("t1_icmc_low", icmc_en, 0);
    step(); ic_en = 1'b0; settle();
    chk("t1_after", icmc_en, 0);
    steps(2);

    // Demand 0x200 and prefetch 0x208 together
    ic_en = 1'b1; ic_addr = 32'h200; pf_en = 1'b1; pf_addr = 32'h208;
    step(); settle();
    chk("t2_dem_addr", icmc_addr, 32'h200);
    steps(10); settle();
    chk("t2_arbic", arbic_en, 1);
    chk("t2_arbpf", arbpf_en, 0);
    step(); ic_en = 1'b0; settle();
    chk("t2_gap", icmc_en, 0);
    step(); settle();
    chk("t2_pf_en", icmc_en, 1);
    chk("t2_pf_addr", icmc_addr, 32'h208);
    steps(10); settle();
    chk("t2_pf_arbpf", arbpf_en, 1);
    chk("t2_pf_arbic", arbic_en, 0);
    chk("t2_pf_block", arb_block, blk_of(32'h208));
    step(); pf_en = 1'b0;
    steps(2);

    // Demand merges into in-flight prefetch 0x300
    txn0 = mc_txn;
    pf_en = 1'b1; pf_addr = 32'h300;
    step(); settle();
    chk("t3_pf_addr", icmc_addr, 32'h300);
    steps(3); ic_en = 1'b1; ic_addr = 32'h300;
    steps(7); settle();
    chk("t3_arbic", arbic_en, 1);
    chk("t3_arbpf", arbpf_en, 1);
    chk("t3_block", arb_block, blk_of(32'h300));
    step(); ic_en = 1'b0; pf_en = 1'b0;
    steps(2); settle();
    chk("t3_one_txn", mc_txn - txn0, 1);
    chk("t3_idle", icmc_en, 0);

    // Flush during fetch 0x400
    ic_en = 1'b1; ic_addr = 32'h400;
    step(); settle();
    chk("t4_req", icmc_addr, 32'h400);
    steps(2); flush = 1'b1; ic_en = 1'b0;
    step(); flush = 1'b0;
    steps(7); settle();
    chk("t4_mcic", mcic_en, 1);
    chk("t4_no_arbic", arbic_en, 0);
    step(); ic_en = 1'b1; ic_addr = 32'h500; settle();
    chk("t4_idle", icmc_en, 0);
    step(); settle();
    chk("t4_new_addr", icmc_addr, 32'h500);
    steps(10); settle();
    chk("t4_new_arbic", arbic_en, 1);
    chk("t4_new_block", arb_block, blk_of(32'h500));
    step(); ic_en = 1'b0;
    steps(2);

    // Flush in IDLE blocks the grant; Sys_rdy low blocks it too
    ic_en = 1'b1; ic_addr = 32'h700; flush = 1'b1;
    step(); flush = 1'b0; settle();
    chk("t5_flush_block", icmc_en, 0);
    rdy = 1'b0;
    step(); settle();
    chk("t5_rdy_block", icmc_en, 0);
    rdy = 1'b1;
    step(); settle();
    chk("t5_grant", icmc_addr, 32'h700);
    chk("t5_grant_en", icmc_en, 1);
    steps(10); settle();
    chk("t5_arbic", arbic_en, 1);
    step(); ic_en = 1'b0;
    steps(2);

    // Continuous demand with prefetch 0x600 held
    pf_en = 1'b1; pf_addr = 32'h600;
    ic_en = 1'b1; ic_addr = 32'h1000;
    step(); settle();
    chk("t6_first", icmc_addr, 32'h1000);
    steps(10); settle();
    chk("t6_first_arbic", arbic_en, 1);
    step(); ic_addr = 32'h1008;
    step(); settle();
`ifdef MEM_ARB_AGE_EN
    chk("t6_age_grant", icmc_addr, 32'h600);
    steps(10); settle();
    chk("t6_age_arbpf", arbpf_en, 1);
    chk("t6_age_arbic", arbic_en, 0);
    step(); pf_en = 1'b0;
    step(); settle();
    chk("t6_dem_resume", icmc_addr, 32'h1008);
    steps(10);
`else
    chk("t6_second", icmc_addr, 32'h1008);
    steps(10); settle();
    chk("t6_second_arbpf", arbpf_en, 0);
    step(); ic_addr = 32'h1010;
    step(); settle();
    chk("t6_third", icmc_addr, 32'h1010);
    steps(10); settle();
    chk("t6_third_arbpf", arbpf_en, 0);
`endif
    step(); ic_en = 1'b0; pf_en = 1'b0;
    steps(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_arbiter.md
# ifetch_arbiter

Sequencer and arbiter for the memory controller's instruction-block read port (ICMC/MCIC). It shares that port between the ICache demand-miss path and the next-line instruction prefetcher, with one transaction in flight at a time. It merges a demand request into an in-flight prefetch of the same block and discards responses invalidated by a pipeline flush. It sits between ICache/prefetcher and MemController; the LSB port of MemController is not touched.

## Interface
- ADDR_WIDTH, 32, address width
- BLOCK_WIDTH, 1, log2 instructions per block; block = 32·2^BLOCK_WIDTH bits
- AGE_WIDTH, 4, prefetch age counter width; age limit = 2^AGE_WIDTH−1 (only with MEM_ARB_AGE_EN)
- Sys_clk  in  1  clock, rising edge
- Sys_rst  in  1  reset, asynchronous, active-high
- Sys_rdy  in  1  global enable; low = all registers hold, response pulses suppressed
- Sys_flush  in  1  pipeline flush (branch mispredict)
- ICARB_en  in  1  ICache demand request, level, held until ARBIC_en or Sys_flush
- ICARB_addr  in  ADDR_WIDTH  block-aligned demand address
- ARBIC_en  out  1  one-cycle pulse: ARB_block valid for ICache
- PFARB_en  in  1  prefetch request, level, held until ARBPF_en or Sys_flush
- PFARB_addr  in  ADDR_WIDTH  block-aligned prefetch address
- ARBPF_en  out  1  one-cycle pulse: ARB_block valid for prefetcher
- ARB_block  out  32·2^BLOCK_WIDTH  combinational pass-through of MCIC_block
- ICMC_en  out  1  request to MemController
- ICMC_addr  out  ADDR_WIDTH  request address to MemController
- MCIC_en  in  1  MemController completion pulse
- MCIC_block  in  32·2^BLOCK_WIDTH  returned block

## Operation
- States: IDLE, BUSY. Registers: cur_addr, own_ic, own_pf, drop, age.
- IDLE, Sys_rdy=1, Sys_flush=0:
  - if ICARB_en: grant demand → BUSY; cur_addr←ICARB_addr; own_ic←1; own_pf←PFARB_en && PFARB_addr==ICARB_addr.
  - else if PFARB_en: → BUSY; cur_addr←PFARB_addr; own_pf←1.
- Priority is strict, demand over prefetch.
- BUSY, no MCIC_en: a matching requester (en=1, addr==cur_addr, drop=0) is merged by setting its own_* bit. A non-matching request waits.
- BUSY, MCIC_en: ARBIC_en = own_ic or matching ICARB_en; ARBPF_en likewise. Both are gated by Sys_rdy && !drop && !Sys_flush. Then → IDLE and own_*/drop are cleared.
- ICMC_en = (state==BUSY) && !MCIC_en, combinational, so MemController never re-samples a finished request. ICMC_addr = cur_addr.
- Sys_flush in BUSY sets drop. The MemController read still completes; its response is discarded and the arbiter returns to IDLE. Sys_flush in IDLE blocks the grant that cycle.
- Flush coincident with MCIC_en: no pulse, → IDLE.
- Requesters must deassert en in the cycle after their pulse unless issuing a new request.

## Timing
- Reset values:
  - state IDLE; cur_addr, own_ic, own_pf, drop, age all 0.
  - ICMC_en 0, ICMC_addr 0, ARBIC_en 0, ARBPF_en 0.
  - ARB_block follows MCIC_block.
- Grant latency: request sampled at edge ending cycle t → ICMC_en high in t+1.
- Completion: MCIC_en in cycle c → ARB*_en in c (same cycle), IDLE in c+1, next ICMC_en no earlier than c+2.
- Sys_rdy low: state frozen; ICMC_en still driven from state; no pulses.

## Configuration
- MEM_ARB_AGE_EN defined:
  - age increments each cycle PFARB_en=1 without prefetch grant/merge, saturating at 2^AGE_WIDTH−1.
  - at saturation, an IDLE grant goes to prefetch even if ICARB_en (different address).
  - age clears on prefetch grant, merge, or Sys_flush.
- Undefined: no age logic, strict demand priority; prefetch may starve.

## Structure
- Shared package/defines: ADDR_WIDTH, BLOCK_WIDTH, block width expression, IDLE/BUSY encodings (shared with MemController state constants).
- One sub-module: arb_age_counter (saturating counter, clear/inc/sat), instantiated only under MEM_ARB_AGE_EN.

## Test plan
MemController model returns MCIC_en 10 cycles after ICMC_en rises; BLOCK_WIDTH=1.
- ICARB_en, addr 0x100 alone → ICMC_en at t+1 with ICMC_addr 0x100; ARBIC_en pulse at t+11 with block; ARBPF_en 0; ICMC_en low that cycle.
- ICARB_en 0x200 and PFARB_en 0x208 same cycle → demand first; prefetch ICMC_addr 0x208 granted ICMC_en exactly 2 cycles after demand completion.
- PF 0x300 in flight; ICARB_en 0x300 raised 4 cycles later → single MemController transaction; ARBIC_en and ARBPF_en pulse together.
- Sys_flush 3 cycles into IC fetch 0x400 → MCIC_en arrives, no ARBIC_en; IDLE next cycle; new request 0x500 granted normally.
- With MEM_ARB_AGE_EN, AGE_WIDTH=2: ICARB_en continuously with new addresses, PFARB_en 0x600 held → prefetch granted after age reaches 3. Without the macro, never granted while demand is held.
